temp_conv_arbiter: RTL and testbench
====================================

Name: temp_conv_arbiter

Overview:
Shares the single ROM temperature converter between NREQ requesters. The converter has a 1-cycle registered read and takes an 8-bit temperature plus a unit bit (1 = Celsius in, 0 = Fahrenheit in). The block round-robin arbitrates, range-checks each request, sequences the ROM access and returns the result with requester ID over a valid/ready response port. It also keeps saturating conversion and error counters, and sits between the UI/host requesters and the converter ROM.

Parameters:
NREQ, 4, number of requesters (2..8)
CNT_W, 16, width of the statistics counters
IDW, $clog2(NREQ) (localparam, derived), width of resp_id

Ports:
clk  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-high reset
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  one-hot grant/accept pulse, combinational in IDLE
req_temperature  in  NREQ*8  packed temperatures, requester i at [8i+7:8i]
req_unit  in  NREQ  per-requester unit bit (1 = C->F, 0 = F->C)
rom_temperature  out  8  registered ROM address
rom_unit  out  1  registered ROM unit select
rom_data  in  8  ROM registered output
resp_valid  out  1  response valid
resp_ready  in  1  response accepted
resp_id  out  IDW  index of the served requester
resp_data  out  8  converted temperature; 8'h00 on error
resp_err  out  1  request out of range
conv_count  out  CNT_W  completed responses, saturating
err_count  out  CNT_W  error responses, saturating

Behaviour:
- One clock, clk. Reset is synchronous and active-high on reset.
- Reset values: state=IDLE, req_ready=0, rom_temperature=0, rom_unit=1, resp_valid=0, resp_id=0, resp_data=0, resp_err=0, both counters=0, round-robin pointer=0.
- A reset asserted in any state, including mid-LOOKUP or mid-RESP, aborts the transaction with no response. Requesters must re-issue.
- FSM states: IDLE, LOOKUP, CAPTURE, RESP.
- IDLE:
  - If any req_valid is set, grant the first valid index searching upward from the pointer, wrapping modulo NREQ.
  - req_ready[g]=1 for that cycle only. Latch the ID, err flag and ROM inputs. Set the pointer to (g+1) mod NREQ. Go to LOOKUP.
  - If no req_valid is set, stay in IDLE and req_ready=0.
- Range check (combinational, at grant):
  - unit=1: err if temp > 100.
  - unit=0: err if temp < 32 or temp > 212.
  - On err, the ROM is driven with temperature 0 and unit 1, so undefined ROM entries are never addressed.
- LOOKUP: rom_temperature/rom_unit hold the latched values. The ROM samples them on this edge. Go to CAPTURE.
- CAPTURE:
  - resp_data <= err ? 8'h00 : rom_data. Set resp_err and resp_id.
  - resp_valid <= 1. Go to RESP.
- RESP:
  - Hold resp_valid and all resp_* stable until resp_ready=1.
  - On the accept edge: resp_valid <= 0, conv_count += 1, err_count += 1 if resp_err, then go to IDLE.
  - No new grant is issued in RESP.
- Timing:
  - Grant cycle to first resp_valid cycle is 3 clocks.
  - Minimum issue interval is 4 clocks (one IDLE bubble after accept).
- Counters saturate at all-ones.
- req_valid dropping before grant is legal; the request is simply not seen.
- Inputs of non-granted requesters are ignored.

Decomposition:
- Package temp_conv_pkg:
  - state enum state_t {IDLE, LOOKUP, CAPTURE, RESP}
  - constants C_MAX=8'd100, F_MIN=8'd32, F_MAX=8'd212, UNIT_C=1'b1, UNIT_F=1'b0, ERR_DATA=8'h00
  - function in_range(temp, unit)
- One sub-module, rr_arbiter (parameter N): request vector, pointer and enable in; one-hot grant and binary index out; pointer update on enable.
- The top level wires rom_* to the ROM converter instance.

Test Plan:
- Req0 valid, C 25 (unit=1) -> req_ready[0] pulse. 3 clocks later resp_valid=1, resp_data=8'h4D (77), resp_err=0, resp_id=0, conv_count=1.
- Req2, F 212 (unit=0) -> resp_data=8'h64 (100). Then F 32 -> 8'h00 with resp_err=0. Both with resp_id=2.
- C 101, then F 31, then F 213 -> each gives resp_err=1, resp_data=8'h00, with rom_temperature=0 and rom_unit=1 during LOOKUP. err_count=3.
- All four req_valid held high, resp_ready=1 -> grants in order 0,1,2,3,0, each spaced 4 clocks. resp_id follows the same order.
- resp_ready low for 5 clocks in RESP -> resp_* stable, req_ready stays 0, counters unchanged. Accept on the 6th clock, then the next grant one clock later.
- Reset pulsed during LOOKUP -> next clock is IDLE, resp_valid=0, pointer=0, and no response appears for the aborted request.

Source files
------------

// File: rtl/temp_conv_pkg.sv
// Shared types, range limits and the range-check helper for the temperature
// converter arbiter.
package temp_conv_pkg;

  typedef enum logic [1:0] {IDLE, LOOKUP, CAPTURE, RESP} state_t;

  localparam logic [7:0] C_MAX    = 8'd100;
  localparam logic [7:0] F_MIN    = 8'd32;
  localparam logic [7:0] F_MAX    = 8'd212;
  localparam logic       UNIT_C   = 1'b1;
  localparam logic       UNIT_F   = 1'b0;
  localparam logic [7:0] ERR_DATA = 8'h00;

  // True when the ROM holds a defined entry for this temperature/unit pair.
  function automatic logic in_range(input logic [7:0] temp, input logic unit);
    if (unit == UNIT_F) begin
      return (temp >= F_MIN) && (temp <= F_MAX);
    end
    return temp <= C_MAX;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches upward from the pointer, wrapping modulo N,
// and moves the pointer past the winner whenever a grant is taken.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req,
  input  logic          en,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW:0]   sum;
  logic [IW-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr_q} + (IW+1)'(k);
      if (sum >= (IW+1)'(N)) begin
        sum = sum - (IW+1)'(N);
      end
      cand = sum[IW-1:0];
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (en && any) begin
      ptr_d = (idx == IW'(N - 1)) ? '0 : idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/temp_conv_arbiter.sv
// Shares one registered-read temperature ROM between NREQ requesters:
// grant, range check, ROM access, then a held valid/ready response.
module temp_conv_arbiter
  import temp_conv_pkg::*;
#(
  parameter  int NREQ  = 4,
  parameter  int CNT_W = 16,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*8-1:0] req_temperature,
  input  logic [NREQ-1:0]   req_unit,
  output logic [7:0]        rom_temperature,
  output logic              rom_unit,
  input  logic [7:0]        rom_data,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [IDW-1:0]    resp_id,
  output logic [7:0]        resp_data,
  output logic              resp_err,
  output logic [CNT_W-1:0]  conv_count,
  output logic [CNT_W-1:0]  err_count
);

  state_t           state_q, state_d;
  logic [IDW-1:0]   id_q, id_d;
  logic             err_q, err_d;
  logic [7:0]       rom_temp_q, rom_temp_d;
  logic             rom_unit_q, rom_unit_d;
  logic             resp_valid_q, resp_valid_d;
  logic [IDW-1:0]   resp_id_q, resp_id_d;
  logic [7:0]       resp_data_q, resp_data_d;
  logic             resp_err_q, resp_err_d;
  logic [CNT_W-1:0] conv_q, conv_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic [7:0]       temp_arr [NREQ];
  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   gnt_idx;
  logic             gnt_any;
  logic             arb_en;
  logic [7:0]       sel_temp;
  logic             sel_unit;
  logic             sel_err;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign temp_arr[gi] = req_temperature[8*gi +: 8];
  end

  // Grants are only offered in IDLE and never while reset is held.
  assign arb_en    = (state_q == IDLE) && !reset;
  assign req_ready = grant & {NREQ{arb_en}};

  rr_arbiter #(.N(NREQ)) u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (req_valid),
    .en    (arb_en),
    .grant (grant),
    .idx   (gnt_idx),
    .any   (gnt_any)
  );

  assign sel_temp = temp_arr[gnt_idx];
  assign sel_unit = req_unit[gnt_idx];
  assign sel_err  = !in_range(sel_temp, sel_unit);

  always_comb begin
    state_d      = state_q;
    id_d         = id_q;
    err_d        = err_q;
    rom_temp_d   = rom_temp_q;
    rom_unit_d   = rom_unit_q;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;
    conv_d       = conv_q;
    err_cnt_d    = err_cnt_q;
    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          id_d       = gnt_idx;
          err_d      = sel_err;
          // Out-of-range requests park the ROM on a known-defined entry.
          rom_temp_d = sel_err ? 8'd0 : sel_temp;
          rom_unit_d = sel_err ? UNIT_C : sel_unit;
          state_d    = LOOKUP;
        end
      end
      LOOKUP: state_d = CAPTURE;
      CAPTURE: begin
        resp_data_d  = err_q ? ERR_DATA : rom_data;
        resp_err_d   = err_q;
        resp_id_d    = id_q;
        resp_valid_d = 1'b1;
        state_d      = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          if (conv_q != '1) conv_d = conv_q + 1'b1;
          if (resp_err_q && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      id_q         <= '0;
      err_q        <= 1'b0;
      rom_temp_q   <= 8'd0;
      rom_unit_q   <= UNIT_C;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_data_q  <= 8'd0;
      resp_err_q   <= 1'b0;
      conv_q       <= '0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      id_q         <= id_d;
      err_q        <= err_d;
      rom_temp_q   <= rom_temp_d;
      rom_unit_q   <= rom_unit_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
      conv_q       <= conv_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign rom_temperature = rom_temp_q;
  assign rom_unit        = rom_unit_q;
  assign resp_valid      = resp_valid_q;
  assign resp_id         = resp_id_q;
  assign resp_data       = resp_data_q;
  assign resp_err        = resp_err_q;
  assign conv_count      = conv_q;
  assign err_count       = err_cnt_q;

endmodule

// File: tb/tb_temp_conv_arbiter.sv
// Randomised and directed bench for temp_conv_arbiter against a
// transaction-level reference model and a behavioural converter ROM.
module tb_temp_conv_arbiter;

  localparam int N  = 4;
  localparam int CW = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [8*N-1:0]  req_temperature = '0;
  logic [N-1:0]    req_unit = '0;
  logic [7:0]      rom_temperature;
  logic            rom_unit;
  logic [7:0]      rom_data;
  logic            resp_valid;
  logic            resp_ready = 1'b0;
  logic [IW-1:0]   resp_id;
  logic [7:0]      resp_data;
  logic            resp_err;
  logic [CW-1:0]   conv_count;
  logic [CW-1:0]   err_count;

  temp_conv_arbiter #(.NREQ(N), .CNT_W(CW)) dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_temperature (req_temperature),
    .req_unit        (req_unit),
    .rom_temperature (rom_temperature),
    .rom_unit        (rom_unit),
    .rom_data        (rom_data),
    .resp_valid      (resp_valid),
    .resp_ready      (resp_ready),
    .resp_id         (resp_id),
    .resp_data       (resp_data),
    .resp_err        (resp_err),
    .conv_count      (conv_count),
    .err_count       (err_count)
  );

  always #5 clk = ~clk;

  // Converter contents; undefined entries return marker bytes.
  function automatic logic [7:0] conv_f(input logic [7:0] t, input logic u);
    if (u) return (t <= 8'd100) ? 8'(int'(t) * 9 / 5 + 32) : 8'hFF;
    return (t >= 8'd32 && t <= 8'd212) ? 8'((int'(t) - 32) * 5 / 9) : 8'hEE;
  endfunction

  function automatic bit ref_err(input logic [7:0] t, input logic u);
    if (u) return t > 8'd100;
    return (t < 8'd32) || (t > 8'd212);
  endfunction

  always @(posedge clk) rom_data <= conv_f(rom_temperature, rom_unit);

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model: 0 = idle, 1 = waiting for ROM, 2 = response pending.
  int         m_phase = 0;
  int         m_wait = 0;
  int         m_ptr = 0;
  int         m_conv = 0;
  int         m_err = 0;
  int         p_id = 0;
  logic [7:0] p_temp = '0;
  logic       p_unit = 1'b0;
  bit         p_err = 1'b0;

  logic [7:0] last_data;
  int         last_id;
  logic       last_err;
  int         grant_log[$];
  int         grant_cyc[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input logic [N-1:0] v, input logic [8*N-1:0] t,
                      input logic [N-1:0] u, input logic rr);
    int g;
    @(negedge clk);
    req_valid = v;
    req_temperature = t;
    req_unit = u;
    resp_ready = rr;
    #1;
    cyc++;
    for (int k = 0; k < N; k++) begin
      if (req_ready[k]) begin
        grant_log.push_back(k);
        grant_cyc.push_back(cyc);
      end
    end
    chk("conv_count", conv_count, m_conv);
    chk("err_count", err_count, m_err);
    case (m_phase)
      0: begin
        g = -1;
        for (int k = 0; k < N; k++) begin
          if (g < 0 && v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        end
        chk("req_ready", req_ready, (g < 0) ? 0 : (1 << g));
        chk("resp_valid_idle", resp_valid, 0);
        if (g >= 0) begin
          p_id = g;
          p_temp = t[8*g +: 8];
          p_unit = u[g];
          p_err = ref_err(p_temp, p_unit);
          m_ptr = (g + 1) % N;
          m_phase = 1;
          m_wait = 2;
        end
      end
      1: begin
        chk("req_ready_busy", req_ready, 0);
        chk("resp_valid_busy", resp_valid, 0);
        if (m_wait == 2) begin
          chk("rom_temperature", rom_temperature, p_err ? 8'd0 : p_temp);
          chk("rom_unit", rom_unit, p_err ? 1'b1 : p_unit);
        end
        m_wait--;
        if (m_wait == 0) m_phase = 2;
      end
      default: begin
        chk("req_ready_resp", req_ready, 0);
        chk("resp_valid", resp_valid, 1);
        chk("resp_id", resp_id, p_id);
        chk("resp_err", resp_err, p_err);
        chk("resp_data", resp_data, p_err ? 8'h00 : conv_f(p_temp, p_unit));
        if (rr) begin
          last_data = resp_data;
          last_id = int'(resp_id);
          last_err = resp_err;
          if (m_conv < (1 << CW) - 1) m_conv++;
          if (p_err && m_err < (1 << CW) - 1) m_err++;
          m_phase = 0;
          $display("txn cyc=%0d id=%0d temp=%0d unit=%0d err=%0d data=%0d", cyc,
                   resp_id, p_temp, p_unit, resp_err, resp_data);
        end
      end
    endcase
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req_valid = '1;
    resp_ready = 1'b1;
    #1;
    chk("rst_req_ready", req_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    req_valid = '0;
    #1;
    cyc++;
    m_phase = 0;
    m_ptr = 0;
    m_conv = 0;
    m_err = 0;
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_rom_temperature", rom_temperature, 0);
    chk("rst_rom_unit", rom_unit, 1);
    chk("rst_resp_id", resp_id, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_conv_count", conv_count, 0);
    chk("rst_err_count", err_count, 0);
  endtask

  // One request from a single requester with random junk on the others.
  task automatic send(input int id, input logic [7:0] temp, input logic unit);
    logic [N-1:0]   v;
    logic [8*N-1:0] t;
    logic [N-1:0]   u;
    v = '0;
    v[id] = 1'b1;
    t = $urandom;
    t[8*id +: 8] = temp;
    u = N'($urandom);
    u[id] = unit;
    step(v, t, u, 1'b1);
    repeat (3) step('0, $urandom, N'($urandom), 1'b1);
    step('0, '0, '0, 1'b1);
  endtask

  initial begin
    do_reset();

    send(0, 8'd25, 1'b1);
    chk("c25_data", last_data, 8'h4D);
    chk("c25_id", last_id, 0);
    chk("c25_err", last_err, 0);
    chk("c25_count", conv_count, 1);

    send(2, 8'd212, 1'b0);
    chk("f212_data", last_data, 8'h64);
    chk("f212_id", last_id, 2);
    send(2, 8'd32, 1'b0);
    chk("f32_data", last_data, 8'h00);
    chk("f32_err", last_err, 0);
    chk("f32_id", last_id, 2);

    send(0, 8'd101, 1'b1);
    chk("c101_err", last_err, 1);
    send(1, 8'd31, 1'b0);
    chk("f31_err", last_err, 1);
    send(3, 8'd213, 1'b0);
    chk("f213_err", last_err, 1);
    chk("f213_data", last_data, 8'h00);
    chk("err_count3", err_count, 3);

    grant_log.delete();
    grant_cyc.delete();
    repeat (20) step('1, $urandom, N'($urandom), 1'b1);
    chk("rr_grants", grant_log.size() >= 5, 1);
    if (grant_log.size() >= 5) begin
      for (int i = 0; i < 5; i++) chk("rr_order", grant_log[i], i % N);
      for (int i = 1; i < 5; i++) chk("rr_gap", grant_cyc[i] - grant_cyc[i-1], 4);
    end

    while (m_phase != 0) step('0, '0, '0, 1'b1);
    step('1, $urandom, N'($urandom), 1'b0);
    repeat (7) step('1, $urandom, N'($urandom), 1'b0);
    step('1, $urandom, N'($urandom), 1'b1);
    step('1, $urandom, N'($urandom), 1'b0);
    chk("stall_regrant", req_ready != '0, 1);
    while (m_phase != 0) step('0, '0, '0, 1'b1);

    step(4'b0100, $urandom, N'($urandom), 1'b1);
    do_reset();
    repeat (5) step('0, '0, '0, 1'b1);
    step('1, $urandom, N'($urandom), 1'b1);
    chk("post_rst_ptr", req_ready, 4'b0001);
    while (m_phase != 0) step('0, '0, '0, 1'b1);

    for (int i = 0; i < 400; i++) begin
      step(N'($urandom), $urandom, N'($urandom), $urandom_range(0, 9) < 7);
    end
    chk("conv_saturated", conv_count, 4'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
